// File: rtl/branch_predict_unit.sv
// Branch resolve/predict unit: resolves branch and jump outcomes at execute,
// predicts at fetch from a PC-indexed table of 2-bit saturating counters,
// flags mispredictions for the flush logic and keeps saturating statistics.
module branch_predict_unit #(
    parameter int unsigned PC_WIDTH       = 16,
    parameter int unsigned BHT_DEPTH      = 16,
    parameter int unsigned ALU_FLAG_COUNT = 4,
    parameter int unsigned FLAG_GT        = 0,
    parameter int unsigned FLAG_EQ        = 1,
    parameter logic [4:0]  OP_JMPADR      = 5'h10,
    parameter logic [4:0]  OP_JMPI        = 5'h11,
    parameter logic [4:0]  OP_BLT         = 5'h12,
    parameter logic [4:0]  OP_BGE         = 5'h13,
    parameter logic [4:0]  OP_BEQ         = 5'h14,
    parameter logic [4:0]  OP_BNEQ        = 5'h15,
    parameter int unsigned STAT_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PC_WIDTH-1:0]       fetch_pc,
    input  logic [4:0]                fetch_opcode,
    output logic                      predict_taken,
    input  logic                      res_valid,
    input  logic [4:0]                res_opcode,
    input  logic [PC_WIDTH-1:0]       res_pc,
    input  logic                      res_pred_taken,
    input  logic [ALU_FLAG_COUNT-1:0] alu_flags,
    output logic                      pc_sel,
    output logic                      mispredict,
    output logic [STAT_WIDTH-1:0]     branch_count,
    output logic [STAT_WIDTH-1:0]     mispredict_count
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);
    localparam logic [1:0] CNT_RESET = 2'b01;
    localparam logic [1:0] CNT_MAX   = 2'b11;
    localparam logic [1:0] CNT_MIN   = 2'b00;
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = {STAT_WIDTH{1'b1}};

    // Opcode class decode shared by the fetch and execute ports
    function automatic logic is_jump(input logic [4:0] op);
        return (op == OP_JMPADR) || (op == OP_JMPI);
    endfunction

    function automatic logic is_cond(input logic [4:0] op);
        return (op == OP_BLT) || (op == OP_BGE) || (op == OP_BEQ) || (op == OP_BNEQ);
    endfunction

    logic [1:0] bht [BHT_DEPTH];

    logic [IDX_W-1:0] fetch_idx_c;
    logic [IDX_W-1:0] res_idx_c;
    logic             flag_gt_c;
    logic             flag_eq_c;
    logic             cond_true_c;
    logic             res_jump_c;
    logic             res_cond_c;
    logic             upd_en_c;
    logic [1:0]       cnt_cur_c;
    logic [1:0]       cnt_next_c;
    logic             mispredict_c;
    logic             unused_ok;

    assign fetch_idx_c = fetch_pc[IDX_W-1:0];
    assign res_idx_c   = res_pc[IDX_W-1:0];
    assign flag_gt_c   = alu_flags[FLAG_GT];
    assign flag_eq_c   = alu_flags[FLAG_EQ];
    assign res_jump_c  = is_jump(res_opcode);
    assign res_cond_c  = is_cond(res_opcode);

    // Upper PC bits and spare ALU flags do not participate in this unit
    assign unused_ok = ^{fetch_pc, res_pc, alu_flags};

    // Fetch-side prediction from the pre-update counter MSB
    always_comb begin
        predict_taken = 1'b0;
        if (is_jump(fetch_opcode)) begin
            predict_taken = 1'b1;
        end else if (is_cond(fetch_opcode)) begin
            predict_taken = bht[fetch_idx_c][1];
        end
    end

    // Branch condition evaluation from ALU flags
    always_comb begin
        cond_true_c = 1'b0;
        unique case (res_opcode)
            OP_BLT:  cond_true_c = ~flag_gt_c & ~flag_eq_c;
            OP_BGE:  cond_true_c = flag_gt_c | flag_eq_c;
            OP_BEQ:  cond_true_c = flag_eq_c;
            OP_BNEQ: cond_true_c = ~flag_eq_c;
            default: cond_true_c = 1'b0;
        endcase
    end

    // Actual outcome at execute and misprediction detection
    always_comb begin
        pc_sel       = res_valid & (res_jump_c | (res_cond_c & cond_true_c));
        upd_en_c     = res_valid & res_cond_c;
        mispredict_c = res_valid & (res_jump_c | res_cond_c) & (pc_sel != res_pred_taken);
    end

    // Saturating counter step for the resolved conditional branch
    always_comb begin
        cnt_cur_c  = bht[res_idx_c];
        cnt_next_c = cnt_cur_c;
        if (pc_sel) begin
            if (cnt_cur_c != CNT_MAX) begin
                cnt_next_c = cnt_cur_c + 2'd1;
            end
        end else begin
            if (cnt_cur_c != CNT_MIN) begin
                cnt_next_c = cnt_cur_c - 2'd1;
            end
        end
    end

    // Counter table: reset to weakly not-taken, write back on conditional resolve
    always_ff @(posedge clk) begin
        if (rst) begin
            bht <= '{default: CNT_RESET};
        end else if (upd_en_c) begin
            bht[res_idx_c] <= cnt_next_c;
        end
    end

    // Registered flush pulse and saturating statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict       <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            mispredict <= mispredict_c;
            if (upd_en_c && (branch_count != STAT_MAX)) begin
                branch_count <= branch_count + STAT_WIDTH'(1);
            end
            if (mispredict_c && (mispredict_count != STAT_MAX)) begin
                mispredict_count <= mispredict_count + STAT_WIDTH'(1);
            end
        end
    end

endmodule
